uart_rx_gen2: RTL and testbench

//  Parametrised successor of the UART receiver. Oversampled serial RX with generic data width,

---
 rtl/uart_rx_gen2.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_rx_gen2.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_gen2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_gen2                                                 |
// | Description : Oversampled UART receiver. Generic data width, runtime       |
// |               parity (even/odd) and 1/2 stop bits, 3-sample majority vote, |
// |               start-glitch rejection, valid/ready output with overrun.     |
// | Ports       : clk, rst (sync, active-low), RX_IN (synchronised serial in), |
// |               prescale (oversampling ratio), PAR_EN, PAR_TYP, STOP_2,      |
// |               m_data/m_valid/m_ready (frame output handshake),             |
// |               parity_error, stop_error (frame flags), overrun (pulse),     |
// |               break_det (pulse, only with UART_RX_BREAK_DET_EN defined).   |
// | Option      : UART_RX_BREAK_DET_EN adds break detection and break_det.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module uart_rx_gen2 #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESC_W-1:0]    prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP_2,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  overrun
`ifdef UART_RX_BREAK_DET_EN
    ,
    output logic                  break_det
`endif
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;
`ifdef UART_RX_BREAK_DET_EN
    localparam logic [2:0] c_ST_BREAK  = 3'd5;
`endif
    localparam logic [3:0]         c_LAST_DATA = 4'(DATA_WIDTH - 1);
    localparam logic [PRESC_W-1:0] c_ONE       = {{(PRESC_W-1){1'b0}}, 1'b1};

    logic [2:0]            r_state;
    logic [PRESC_W-1:0]    r_edge_cnt;
    logic [3:0]            r_bit_cnt;
    logic [PRESC_W-1:0]    r_presc;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_stop2;
    logic                  r_s0;
    logic                  r_s1;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_bit;
    logic                  r_stop_err;
`ifdef UART_RX_BREAK_DET_EN
    logic                  r_stop1_zero;
`endif

    logic [PRESC_W-1:0] w_half;
    logic               w_is_s0;
    logic               w_is_s1;
    logic               w_is_vote;
    logic               w_is_last;
    logic               w_vote;
    logic               w_last_stop;
    logic               w_complete;
    logic               w_frame_pe;
    logic               w_frame_se;
    logic               w_break;

    // Sample points sit around mid-bit; the third sample is taken together
    // with the vote so the decision uses the live RX_IN value.
    assign w_half      = {1'b0, r_presc[PRESC_W-1:1]};
    assign w_is_s0     = (r_edge_cnt == (w_half - c_ONE));
    assign w_is_s1     = (r_edge_cnt == w_half);
    assign w_is_vote   = (r_edge_cnt == (w_half + c_ONE));
    assign w_is_last   = (r_edge_cnt == (r_presc - c_ONE));
    assign w_vote      = (r_s0 & r_s1) | (r_s0 & RX_IN) | (r_s1 & RX_IN);
    assign w_last_stop = r_stop2 ? (r_bit_cnt == 4'd1) : (r_bit_cnt == 4'd0);
    assign w_complete  = (r_state == c_ST_STOP) && w_is_vote && w_last_stop;
    assign w_frame_pe  = r_par_en & ((^r_shift) ^ r_par_typ ^ r_par_bit);
    assign w_frame_se  = r_stop_err | ~w_vote;

`ifdef UART_RX_BREAK_DET_EN
    logic w_first_stop0;
    // With one stop bit the first stop bit is the one being voted right now.
    assign w_first_stop0 = (r_bit_cnt == 4'd0) ? ~w_vote : r_stop1_zero;
    assign w_break = (r_shift == '0) && (!r_par_en || !r_par_bit) && w_first_stop0;
`else
    assign w_break = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= c_ST_IDLE;
            r_edge_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_presc      <= '0;
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_stop2      <= 1'b0;
            r_s0         <= 1'b0;
            r_s1         <= 1'b0;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_stop_err   <= 1'b0;
            m_data       <= '0;
            m_valid      <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            overrun      <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            r_stop1_zero <= 1'b0;
            break_det    <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            break_det <= w_complete && w_break;
`endif
            // Output side: a completing frame takes priority over a plain
            // consume because it also covers the consume-and-reload case.
            if (w_complete && !w_break) begin
                if (!m_valid || m_ready) begin
                    m_data       <= r_shift;
                    m_valid      <= 1'b1;
                    parity_error <= w_frame_pe;
                    stop_error   <= w_frame_se;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (m_valid && m_ready) begin
                m_valid      <= 1'b0;
                parity_error <= 1'b0;
                stop_error   <= 1'b0;
            end

            if (r_state != c_ST_IDLE) begin
                if (w_is_s0) r_s0 <= RX_IN;
                if (w_is_s1) r_s1 <= RX_IN;
                r_edge_cnt <= w_is_last ? '0 : (r_edge_cnt + c_ONE);
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (!RX_IN) begin
                        r_state    <= c_ST_START;
                        r_edge_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_presc    <= prescale;
                        r_par_en   <= PAR_EN;
                        r_par_typ  <= PAR_TYP;
                        r_stop2    <= STOP_2;
                        r_stop_err <= 1'b0;
                    end
                end
                c_ST_START: begin
                    if (w_is_vote && w_vote) begin
                        r_state <= c_ST_IDLE;   // glitch, not a real start bit
                    end else if (w_is_last) begin
                        r_state   <= c_ST_DATA;
                        r_bit_cnt <= '0;
                    end
                end
                c_ST_DATA: begin
                    if (w_is_vote) r_shift <= {w_vote, r_shift[DATA_WIDTH-1:1]};
                    if (w_is_last) begin
                        if (r_bit_cnt == c_LAST_DATA) begin
                            r_state   <= r_par_en ? c_ST_PARITY : c_ST_STOP;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end
                c_ST_PARITY: begin
                    if (w_is_vote) r_par_bit <= w_vote;
                    if (w_is_last) begin
                        r_state   <= c_ST_STOP;
                        r_bit_cnt <= '0;
                    end
                end
                c_ST_STOP: begin
                    if (w_is_vote) begin
                        if (!w_vote) r_stop_err <= 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                        if (r_bit_cnt == 4'd0) r_stop1_zero <= ~w_vote;
`endif
                    end
                    if (w_complete) begin
`ifdef UART_RX_BREAK_DET_EN
                        if (w_break) begin
                            r_state    <= c_ST_BREAK;
                            r_edge_cnt <= '0;
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
`else
                        r_state <= c_ST_IDLE;
`endif
                    end else if (w_is_last) begin
                        // An illegal prescale may never reach the vote point;
                        // leaving here guarantees the FSM cannot hang.
                        if (w_last_stop) r_state <= c_ST_IDLE;
                        else             r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                end
`ifdef UART_RX_BREAK_DET_EN
                c_ST_BREAK: begin
                    // Require one full bit time of continuous idle line.
                    if (!RX_IN)         r_edge_cnt <= '0;
                    else if (w_is_last) r_state    <= c_ST_IDLE;
                end
`endif
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_gen2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_rx_gen2                                              |
// | Description : Directed self-checking bench for uart_rx_gen2 (8-bit and     |
// |               7-bit instances sharing the serial line).                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_uart_rx_gen2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rx;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic       stop_2;
    logic       m_ready;

    logic [7:0] m_data;
    logic       m_valid;
    logic       pe;
    logic       se;
    logic       ovr;

    logic [6:0] m_data7;
    logic       m_valid7;
    logic       pe7;
    logic       se7;
    logic       ovr7;
    logic       m_ready7 = 1'b1;

`ifdef UART_RX_BREAK_DET_EN
    logic brk8;
    logic brk7;
`endif

    uart_rx_gen2 #(.DATA_WIDTH(8), .PRESC_W(6)) u_dut8 (
        .clk(clk), .rst(rst), .RX_IN(rx), .prescale(prescale),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP_2(stop_2),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .parity_error(pe), .stop_error(se), .overrun(ovr)
`ifdef UART_RX_BREAK_DET_EN
        , .break_det(brk8)
`endif
    );

    uart_rx_gen2 #(.DATA_WIDTH(7), .PRESC_W(6)) u_dut7 (
        .clk(clk), .rst(rst), .RX_IN(rx), .prescale(prescale),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP_2(stop_2),
        .m_data(m_data7), .m_valid(m_valid7), .m_ready(m_ready7),
        .parity_error(pe7), .stop_error(se7), .overrun(ovr7)
`ifdef UART_RX_BREAK_DET_EN
        , .break_det(brk7)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Output monitor: records every accepted frame and counts activity.
    int         beats8 = 0;
    int         vcyc8  = 0;
    int         ovr8   = 0;
    int         beats7 = 0;
    logic [7:0] cap_d  [0:31];
    logic       cap_pe [0:31];
    logic       cap_se [0:31];
    logic [6:0] cap7;

    always @(negedge clk) begin
        if (m_valid === 1'b1) vcyc8 = vcyc8 + 1;
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            cap_d[beats8 % 32]  = m_data;
            cap_pe[beats8 % 32] = pe;
            cap_se[beats8 % 32] = se;
            beats8 = beats8 + 1;
        end
        if (ovr === 1'b1) ovr8 = ovr8 + 1;
        if (m_valid7 === 1'b1) begin
            cap7   = m_data7;
            beats7 = beats7 + 1;
        end
    end

    // All line changes happen on the falling edge, each bit lasting n clocks.
    task automatic send_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int p, input logic [8:0] d, input int nb,
                              input logic pen, input logic pbit,
                              input logic s1, input logic two, input logic s2);
        send_bit(1'b0, p);
        for (int i = 0; i < nb; i++) send_bit(d[i], p);
        if (pen) send_bit(pbit, p);
        send_bit(s1, p);
        if (two) send_bit(s2, p);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; rx = 1'b1; m_ready = 1'b0;
        prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0; stop_2 = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({m_valid, pe, se, ovr} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b want 0000", {m_valid, pe, se, ovr});
        end
        total++;
        if (m_data !== 8'h00) begin
            bad++; $display("FAIL reset_data: got %h want 00", m_data);
        end
        total++;
        if (m_valid7 !== 1'b0) begin
            bad++; $display("FAIL reset_valid7: got %b want 0", m_valid7);
        end
        rst = 1'b1;
        idle(5);
    endtask

    task automatic test_basic_parity();
        int b0 = beats8;
        int v0 = vcyc8;
        prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0; stop_2 = 1'b0; m_ready = 1'b1;
        send_frame(8, 9'h0A5, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(16);
        total++;
        if (beats8 - b0 !== 1) begin
            bad++; $display("FAIL t1_beats: got %0d want 1", beats8 - b0);
        end
        total++;
        if (vcyc8 - v0 !== 1) begin
            bad++; $display("FAIL t1_valid_cycles: got %0d want 1", vcyc8 - v0);
        end
        total++;
        if ({cap_d[b0 % 32], cap_pe[b0 % 32], cap_se[b0 % 32]} !== {8'hA5, 2'b00}) begin
            bad++; $display("FAIL t1_frame: got %h pe=%b se=%b want a5 pe=0 se=0",
                            cap_d[b0 % 32], cap_pe[b0 % 32], cap_se[b0 % 32]);
        end
    endtask

    task automatic test_two_stop_error();
        int b0 = beats8;
        prescale = 6'd16; par_en = 1'b1; par_typ = 1'b1; stop_2 = 1'b1; m_ready = 1'b1;
        // 0x3C has four ones -> odd parity bit is 1; second stop bit is 0.
        send_frame(16, 9'h03C, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(32);
        total++;
        if (beats8 - b0 !== 1) begin
            bad++; $display("FAIL t2_beats: got %0d want 1", beats8 - b0);
        end
        total++;
        if ({cap_d[b0 % 32], cap_pe[b0 % 32], cap_se[b0 % 32]} !== {8'h3C, 2'b01}) begin
            bad++; $display("FAIL t2_frame: got %h pe=%b se=%b want 3c pe=0 se=1",
                            cap_d[b0 % 32], cap_pe[b0 % 32], cap_se[b0 % 32]);
        end
    endtask

    task automatic test_parity_error();
        int b0 = beats8;
        prescale = 6'd32; par_en = 1'b1; par_typ = 1'b0; stop_2 = 1'b0; m_ready = 1'b1;
        send_frame(32, 9'h00F, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(64);
        total++;
        if ({cap_d[b0 % 32], cap_pe[b0 % 32], cap_se[b0 % 32]} !== {8'h0F, 2'b10}
            || beats8 - b0 !== 1) begin
            bad++; $display("FAIL t3_frame: got %h pe=%b se=%b beats=%0d want 0f pe=1 se=0 beats=1",
                            cap_d[b0 % 32], cap_pe[b0 % 32], cap_se[b0 % 32], beats8 - b0);
        end
    endtask

    task automatic test_overrun();
        int b0 = beats8;
        int o0 = ovr8;
        prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0; stop_2 = 1'b0; m_ready = 1'b0;
        send_frame(8, 9'h055, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        send_frame(8, 9'h096, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(16);
        total++;
        if (m_valid !== 1'b1 || m_data !== 8'h55) begin
            bad++; $display("FAIL t4_held: got valid=%b data=%h want valid=1 data=55", m_valid, m_data);
        end
        total++;
        if (ovr8 - o0 !== 1) begin
            bad++; $display("FAIL t4_overrun: got %0d pulse cycles want 1", ovr8 - o0);
        end
        m_ready = 1'b1;
        idle(4);
        total++;
        if (beats8 - b0 !== 1 || cap_d[b0 % 32] !== 8'h55 || m_valid !== 1'b0) begin
            bad++; $display("FAIL t4_drain: got beats=%0d data=%h valid=%b want 1 55 0",
                            beats8 - b0, cap_d[b0 % 32], m_valid);
        end
    endtask

    task automatic test_back_to_back();
        int b0 = beats8;
        int o0 = ovr8;
        prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0; stop_2 = 1'b0; m_ready = 1'b1;
        send_frame(8, 9'h012, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        send_frame(8, 9'h034, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(16);
        total++;
        if (beats8 - b0 !== 2 || ovr8 - o0 !== 0) begin
            bad++; $display("FAIL b2b_count: got beats=%0d ovr=%0d want 2 0", beats8 - b0, ovr8 - o0);
        end
        total++;
        if (cap_d[b0 % 32] !== 8'h12 || cap_d[(b0 + 1) % 32] !== 8'h34) begin
            bad++; $display("FAIL b2b_data: got %h %h want 12 34", cap_d[b0 % 32], cap_d[(b0 + 1) % 32]);
        end
    endtask

    task automatic test_glitch();
        int b0 = beats8;
        prescale = 6'd16; par_en = 1'b0; par_typ = 1'b0; stop_2 = 1'b0; m_ready = 1'b1;
        send_bit(1'b0, 3);
        idle(48);
        total++;
        if (beats8 - b0 !== 0) begin
            bad++; $display("FAIL t5_glitch: got %0d beats want 0", beats8 - b0);
        end
        send_frame(16, 9'h081, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(32);
        total++;
        if (beats8 - b0 !== 1 || cap_d[b0 % 32] !== 8'h81 || cap_se[b0 % 32] !== 1'b0) begin
            bad++; $display("FAIL t5_frame: got beats=%0d data=%h se=%b want 1 81 0",
                            beats8 - b0, cap_d[b0 % 32], cap_se[b0 % 32]);
        end
    endtask

    task automatic test_latch();
        int b0 = beats8;
        logic [7:0] d = 8'hC3;
        prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0; stop_2 = 1'b0; m_ready = 1'b1;
        send_bit(1'b0, 8);
        // Settings change mid-frame must not affect this frame.
        prescale = 6'd16; par_en = 1'b1; par_typ = 1'b1; stop_2 = 1'b1;
        for (int i = 0; i < 8; i++) send_bit(d[i], 8);
        send_bit(1'b1, 8);
        idle(8);
        send_bit(1'b0, 1);
        idle(40);
        total++;
        if (cap_d[b0 % 32] !== 8'hC3 || {cap_pe[b0 % 32], cap_se[b0 % 32]} !== 2'b00) begin
            bad++; $display("FAIL latch_frame: got %h pe=%b se=%b want c3 pe=0 se=0",
                            cap_d[b0 % 32], cap_pe[b0 % 32], cap_se[b0 % 32]);
        end
        prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0; stop_2 = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int b7 = beats7;
        prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0; stop_2 = 1'b0;
        idle(16);
        send_bit(1'b0, 8);
        send_bit(1'b1, 8);
        send_bit(1'b1, 8);
        send_bit(1'b1, 8);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(40);
        total++;
        if (beats7 - b7 !== 0) begin
            bad++; $display("FAIL t6_aborted: got %0d beats want 0", beats7 - b7);
        end
        send_frame(8, 9'h019, 7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(16);
        total++;
        if (beats7 - b7 !== 1 || cap7 !== 7'h19) begin
            bad++; $display("FAIL t6_frame: got beats=%0d data=%h want 1 19", beats7 - b7, cap7);
        end
    endtask

    initial begin
        rx = 1'b1;
        rst = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_parity();
        test_two_stop_error();
        test_parity_error();
        test_overrun();
        test_back_to_back();
        test_glitch();
        test_latch();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
